// File: rtl/instr_sequencer.sv
// Instruction sequencer: streams words from a small program memory to a CPU,
// holding each word for a class-dependent number of cycles, with single-step and abort.
module instr_sequencer #(
    parameter int INSTR_WIDTH  = 20,
    parameter int PC_BITS      = 4,
    parameter int STD_CYCLES   = 3,
    parameter int LOAD_CYCLES  = 4,
    parameter int STORE_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_wen,
    input  logic [PC_BITS-1:0]     prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   step_mode,
    input  logic                   step,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             retired
);

    localparam int DEPTH  = 2 ** PC_BITS;
    localparam int CLS_HI = INSTR_WIDTH - 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_STEP = 2'd2;

    localparam logic [1:0]             CLS_HALT = 2'b00;
    localparam logic [PC_BITS-1:0]     PC_ZERO  = {PC_BITS{1'b0}};
    localparam logic [PC_BITS-1:0]     PC_ONE   = {{(PC_BITS-1){1'b0}}, 1'b1};
    localparam logic [PC_BITS-1:0]     PC_LAST  = {PC_BITS{1'b1}};
    localparam logic [INSTR_WIDTH-1:0] NOP_WORD = {INSTR_WIDTH{1'b0}};

    // Counter preload is N-1 so that the word stays on the bus for exactly N cycles.
    function automatic logic [7:0] hold_reload(input logic [1:0] cls);
        logic [7:0] r;
        case (cls)
            2'b01:   r = 8'(STD_CYCLES - 1);
            2'b10:   r = 8'(LOAD_CYCLES - 1);
            2'b11:   r = 8'(STORE_CYCLES - 1);
            default: r = 8'd0;
        endcase
        return r;
    endfunction

    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

    logic [1:0]             state_q,   state_d;
    logic [INSTR_WIDTH-1:0] instr_q,   instr_d;
    logic [PC_BITS-1:0]     pc_q,      pc_d;
    logic [7:0]             cnt_q,     cnt_d;
    logic [7:0]             retired_q, retired_d;
    logic                   done_q,    done_d;
    logic                   busy_q,    busy_d;

    logic [INSTR_WIDTH-1:0] first_word_s;
    logic [1:0]             first_cls_s;
    logic [PC_BITS-1:0]     pc_inc_s;
    logic [INSTR_WIDTH-1:0] next_word_s;
    logic [1:0]             next_cls_s;
    logic                   halt_next_s;
    logic [7:0]             retired_inc_s;

    // Look-ahead on the word at address 0 and on the word after the current pc.
    always_comb begin
        first_word_s  = mem_q[PC_ZERO];
        first_cls_s   = first_word_s[CLS_HI -: 2];
        pc_inc_s      = pc_q + PC_ONE;
        next_word_s   = mem_q[pc_inc_s];
        next_cls_s    = next_word_s[CLS_HI -: 2];
        halt_next_s   = (pc_q == PC_LAST) || (next_cls_s == CLS_HALT);
        retired_inc_s = (retired_q == 8'hFF) ? 8'hFF : (retired_q + 8'd1);
    end

    // Sequencer next-state logic; abort outranks both counter expiry and step.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        retired_d = retired_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d      = PC_ZERO;
                    retired_d = 8'd0;
                    if (first_cls_s != CLS_HALT) begin
                        state_d = S_ISSUE;
                        instr_d = first_word_s;
                        cnt_d   = hold_reload(first_cls_s);
                    end else begin
                        instr_d = NOP_WORD;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    instr_d = NOP_WORD;
                    pc_d    = PC_ZERO;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    retired_d = retired_inc_s;
                    if (halt_next_s) begin
                        state_d = S_IDLE;
                        instr_d = NOP_WORD;
                        pc_d    = PC_ZERO;
                        done_d  = 1'b1;
                    end else if (step_mode) begin
                        state_d = S_WAIT_STEP;
                    end else begin
                        pc_d    = pc_inc_s;
                        instr_d = next_word_s;
                        cnt_d   = hold_reload(next_cls_s);
                    end
                end
            end
            S_WAIT_STEP: begin
                // The halt check was done at expiry, so mem[pc+1] is known to be issuable.
                if (abort) begin
                    state_d = S_IDLE;
                    instr_d = NOP_WORD;
                    pc_d    = PC_ZERO;
                end else if (step) begin
                    state_d = S_ISSUE;
                    pc_d    = pc_inc_s;
                    instr_d = next_word_s;
                    cnt_d   = hold_reload(next_cls_s);
                end else begin
                    state_d = S_WAIT_STEP;
                end
            end
            default: begin
                state_d = S_IDLE;
                instr_d = NOP_WORD;
                pc_d    = PC_ZERO;
                cnt_d   = 8'd0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            instr_q   <= NOP_WORD;
            pc_q      <= PC_ZERO;
            cnt_q     <= 8'd0;
            retired_q <= 8'd0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            retired_q <= retired_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    // Program memory keeps its contents through reset; writes land only while idle.
    always_ff @(posedge clk) begin
        if (prog_wen && (state_q == S_IDLE)) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign instruction = instr_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a vector table for the basic two-word
// program plus hand-written sequences for stepping, abort, reset and full-memory runs.
module tb_instr_sequencer;

    logic        clk;
    logic        rst_n;
    logic        prog_wen;
    logic [3:0]  prog_addr;
    logic [19:0] prog_data;
    logic        start;
    logic        abort;
    logic        step_mode;
    logic        step;
    logic [19:0] instruction;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    logic [7:0]  retired;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        start;
        logic        abort;
        logic        step;
        logic [19:0] instr;
        logic [3:0]  pc;
        logic        busy;
        logic        done;
        logic [7:0]  ret;
    } vec_t;

    vec_t tbl [9];

    instr_sequencer dut (
        .clk         (clk),
        .rst         (rst_n),
        .prog_wen    (prog_wen),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .start       (start),
        .abort       (abort),
        .step_mode   (step_mode),
        .step        (step),
        .instruction (instruction),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .retired     (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [19:0] ei, input logic [3:0] ep,
                       input logic eb, input logic ed, input logic [7:0] er);
        n_vec++;
        if (instruction !== ei || pc !== ep || busy !== eb || done !== ed || retired !== er) begin
            n_err++;
            $display("FAIL %s: got instr=%h pc=%0d busy=%b done=%b retired=%0d, want instr=%h pc=%0d busy=%b done=%b retired=%0d",
                     nm, instruction, pc, busy, done, retired, ei, ep, eb, ed, er);
        end
    endtask

    task automatic cyc(input logic s, input logic a, input logic st);
        start = s;
        abort = a;
        step  = st;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        step  = 1'b0;
    endtask

    task automatic load(input logic [3:0] addr, input logic [19:0] data);
        prog_wen  = 1'b1;
        prog_addr = addr;
        prog_data = data;
        @(posedge clk);
        #1;
        prog_wen  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; prog_wen = 1'b0; prog_addr = 4'd0; prog_data = 20'h0;
        start = 1'b0; abort = 1'b0; step_mode = 1'b0; step = 1'b0;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 20'h84010, 4'd0, 1'b1, 1'b0, 8'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 20'h84010, 4'd0, 1'b1, 1'b0, 8'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 20'h84010, 4'd0, 1'b1, 1'b0, 8'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 20'h84010, 4'd0, 1'b1, 1'b0, 8'd0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 20'hC4010, 4'd1, 1'b1, 1'b0, 8'd1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 20'hC4010, 4'd1, 1'b1, 1'b0, 8'd1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 20'hC4010, 4'd1, 1'b1, 1'b0, 8'd1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 20'h00000, 4'd0, 1'b0, 1'b1, 8'd2};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 20'h00000, 4'd0, 1'b0, 1'b0, 8'd2};

        // Reset behaviour and quiet idle afterwards
        #2 rst_n = 1'b0;
        #1 chk("reset_async", 20'h0, 4'd0, 1'b0, 1'b0, 8'd0);
        #20 chk("reset_held", 20'h0, 4'd0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk("idle_after_reset", 20'h0, 4'd0, 1'b0, 1'b0, 8'd0);
        end

        // Single class-01 instruction then halt
        load(4'd0, 20'h64000);
        load(4'd1, 20'h00000);
        chk("idle_after_load", 20'h0, 4'd0, 1'b0, 1'b0, 8'd0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("std_c1", 20'h64000, 4'd0, 1'b1, 1'b0, 8'd0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("std_c2", 20'h64000, 4'd0, 1'b1, 1'b0, 8'd0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("std_c3", 20'h64000, 4'd0, 1'b1, 1'b0, 8'd0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("std_done", 20'h0, 4'd0, 1'b0, 1'b1, 8'd1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("std_done_end", 20'h0, 4'd0, 1'b0, 1'b0, 8'd1);

        // Two-instruction program from the vector table (includes ignored start/step/abort)
        load(4'd0, 20'h84010);
        load(4'd1, 20'hC4010);
        load(4'd2, 20'h00000);
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].start, tbl[i].abort, tbl[i].step);
            chk($sformatf("table_%0d", i), tbl[i].instr, tbl[i].pc, tbl[i].busy, tbl[i].done, tbl[i].ret);
        end

        // Step mode: hold in WAIT_STEP until a step arrives
        step_mode = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        chk("step_issue0", 20'h84010, 4'd0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk("step_hold0", 20'h84010, 4'd0, 1'b1, 1'b0, 8'd0);
        end
        cyc(1'b0, 1'b0, 1'b0);
        chk("step_enter_wait", 20'h84010, 4'd0, 1'b1, 1'b0, 8'd1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk("step_wait", 20'h84010, 4'd0, 1'b1, 1'b0, 8'd1);
        end
        cyc(1'b0, 1'b0, 1'b1);
        chk("step_issue1", 20'hC4010, 4'd1, 1'b1, 1'b0, 8'd1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("step_hold1", 20'hC4010, 4'd1, 1'b1, 1'b0, 8'd1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("step_done", 20'h0, 4'd0, 1'b0, 1'b1, 8'd2);

        // Abort while parked in WAIT_STEP beats a simultaneous step
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
        chk("wait_before_abort", 20'h84010, 4'd0, 1'b1, 1'b0, 8'd1);
        cyc(1'b0, 1'b1, 1'b1);
        chk("wait_abort", 20'h0, 4'd0, 1'b0, 1'b0, 8'd1);
        step_mode = 1'b0;

        // Abort in cycle 2 of a class-10 instruction
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("abort_pre", 20'h84010, 4'd0, 1'b1, 1'b0, 8'd0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("abort_c2", 20'h0, 4'd0, 1'b0, 1'b0, 8'd0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("abort_no_done", 20'h0, 4'd0, 1'b0, 1'b0, 8'd0);

        // Abort coinciding with counter expiry: no retire, no advance, no done
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
        chk("expiry_pre", 20'h84010, 4'd0, 1'b1, 1'b0, 8'd0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("expiry_abort", 20'h0, 4'd0, 1'b0, 1'b0, 8'd0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("expiry_abort_quiet", 20'h0, 4'd0, 1'b0, 1'b0, 8'd0);

        // Reset mid-ISSUE: immediate clear, no done, memory retained
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1 chk("reset_mid_issue", 20'h0, 4'd0, 1'b0, 1'b0, 8'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_no_done", 20'h0, 4'd0, 1'b0, 1'b0, 8'd0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("mem_retained", 20'h84010, 4'd0, 1'b1, 1'b0, 8'd0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("mem_retained_abort", 20'h0, 4'd0, 1'b0, 1'b0, 8'd0);

        // Halt word at address 0
        load(4'd0, 20'h00000);
        cyc(1'b1, 1'b0, 1'b0);
        chk("halt_start", 20'h0, 4'd0, 1'b0, 1'b1, 8'd0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("halt_start_end", 20'h0, 4'd0, 1'b0, 1'b0, 8'd0);

        // Full memory run with a write attempted mid-run
        for (int a = 0; a < 16; a++) load(4'(a), 20'h64000);
        cyc(1'b1, 1'b0, 1'b0);
        chk("full_0", 20'h64000, 4'd0, 1'b1, 1'b0, 8'd0);
        for (int i = 1; i < 48; i++) begin
            if (i == 5) begin
                prog_wen  = 1'b1;
                prog_addr = 4'd3;
                prog_data = 20'h00000;
            end
            cyc(1'b0, 1'b0, 1'b0);
            prog_wen = 1'b0;
            chk($sformatf("full_%0d", i), 20'h64000, 4'(i / 3), 1'b1, 1'b0, 8'(i / 3));
        end
        cyc(1'b0, 1'b0, 1'b0);
        chk("full_done", 20'h0, 4'd0, 1'b0, 1'b1, 8'd16);
        cyc(1'b0, 1'b0, 1'b0);
        chk("full_done_end", 20'h0, 4'd0, 1'b0, 1'b0, 8'd16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
